// File: rtl/controle_microondas.sv
// Microwave timer sequencer: keypad entry of a BCD M:ST:SO time, 1 Hz countdown,
// start/stop/clear and door interlock, magnetron enable and end-of-cycle flag.
module controle_microondas #(
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  input  logic       door_closed,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COOK    = 2'd1,
    PAUSE   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] DONE_LIM = DONE_TICKS[3:0];

  state_t      st, st_nxt;
  logic [11:0] tm, tm_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [11:0] tm_dec;
  logic [3:0]  cnt_inc;

  // One-second BCD decrement; tens digits 6..9 simply count down like any other.
  function automatic logic [11:0] bcd_dec(input logic [11:0] t);
    logic [11:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[7:4] = t[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else if (t[11:8] != 4'd0) begin
      r[11:8] = t[11:8] - 4'd1;
      r[7:4]  = 4'd5;
      r[3:0]  = 4'd9;
    end
    return r;
  endfunction

  assign tm_dec  = bcd_dec(tm);
  assign cnt_inc = cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= IDLE;
      tm  <= 12'd0;
      cnt <= 4'd0;
    end else begin
      st  <= st_nxt;
      tm  <= tm_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    tm_nxt  = tm;
    cnt_nxt = cnt;
    if (clear_btn) begin
      st_nxt = IDLE;
      tm_nxt = 12'd0;
    end else begin
      case (st)
        IDLE: begin
          if (start_btn) begin
            if (door_closed && (tm != 12'd0)) st_nxt = COOK;
          end else if (key_valid && (key_digit <= 4'd9)) begin
            tm_nxt = {tm[7:0], key_digit};
          end
        end
        COOK: begin
          if (!door_closed || stop_btn) begin
            st_nxt = PAUSE;
          end else if (tick_1hz) begin
            tm_nxt = tm_dec;
            if (tm_dec == 12'd0) begin
              st_nxt  = ST_DONE;
              cnt_nxt = 4'd0;
            end
          end
        end
        PAUSE: begin
          if (stop_btn) begin
            st_nxt = IDLE;
            tm_nxt = 12'd0;
          end else if (start_btn && door_closed) begin
            st_nxt = COOK;
          end
        end
        default: begin
          // Any button cancels the end-of-cycle indication early.
          if (stop_btn || start_btn) begin
            st_nxt = IDLE;
          end else if (tick_1hz) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == DONE_LIM) st_nxt = IDLE;
          end
          tm_nxt = 12'd0;
        end
      endcase
    end
  end

  assign mins     = tm[11:8];
  assign sec_tens = tm[7:4];
  assign sec_ones = tm[3:0];
  assign mag_on   = (st == COOK);
  assign done     = (st == ST_DONE);
  assign state    = st;

endmodule

// File: tb/tb_controle_microondas.sv
// Directed bench for controle_microondas: one task per scenario, inline checks
// against hand-computed BCD times and states.
module tb_controle_microondas;

  logic       clk;
  logic       reset;
  logic       tick_1hz;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start_btn;
  logic       stop_btn;
  logic       clear_btn;
  logic       door_closed;
  logic [3:0] mins;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       mag_on;
  logic       done;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  controle_microondas #(.DONE_TICKS(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .start_btn  (start_btn),
    .stop_btn   (stop_btn),
    .clear_btn  (clear_btn),
    .door_closed(door_closed),
    .mins       (mins),
    .sec_tens   (sec_tens),
    .sec_ones   (sec_ones),
    .mag_on     (mag_on),
    .done       (done),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it and pulses drop.
  task automatic cyc();
    @(posedge clk);
    #1;
    tick_1hz  = 1'b0;
    key_valid = 1'b0;
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    clear_btn = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    cyc();
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc();
  endtask

  task automatic start();
    start_btn = 1'b1;
    cyc();
  endtask

  task automatic stop();
    stop_btn = 1'b1;
    cyc();
  endtask

  task automatic clear();
    clear_btn = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h000) begin
      bad++; $display("FAIL reset_time got=%h want=000", {mins, sec_tens, sec_ones});
    end
    total++;
    if ({state, mag_on, done} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl state/mag/done got=%b want=0000", {state, mag_on, done});
    end
  endtask

  task automatic test_keys_start();
    key(4'd1); key(4'd3); key(4'd0);
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h130 || state !== 2'd0) begin
      bad++; $display("FAIL keys_130 got=%h st=%0d want=130 st=0", {mins, sec_tens, sec_ones}, state);
    end
    start();
    total++;
    if (state !== 2'd1 || mag_on !== 1'b1 || {mins, sec_tens, sec_ones} !== 12'h130) begin
      bad++; $display("FAIL start_cook got st=%0d mag=%b t=%h want st=1 mag=1 t=130", state, mag_on, {mins, sec_tens, sec_ones});
    end
    tick();
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h129) begin
      bad++; $display("FAIL tick_129 got=%h want=129", {mins, sec_tens, sec_ones});
    end
  endtask

  task automatic test_rollover();
    clear();
    total++;
    if (state !== 2'd0 || {mins, sec_tens, sec_ones} !== 12'h000) begin
      bad++; $display("FAIL clear_cook got st=%0d t=%h want st=0 t=000", state, {mins, sec_tens, sec_ones});
    end
    key(4'd1); key(4'd0); key(4'd0);
    start();
    tick();
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h059) begin
      bad++; $display("FAIL roll_min got=%h want=059", {mins, sec_tens, sec_ones});
    end
    clear();
    key(4'd1); key(4'd0);
    start();
    tick();
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h009) begin
      bad++; $display("FAIL roll_tens got=%h want=009", {mins, sec_tens, sec_ones});
    end
    clear();
    key(4'd1); key(4'd2);
    for (int d = 10; d < 16; d++) key(4'(d));
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h012) begin
      bad++; $display("FAIL bad_digits got=%h want=012", {mins, sec_tens, sec_ones});
    end
  endtask

  task automatic test_door_pause();
    clear();
    key(4'd4); key(4'd5);
    start();
    door_closed = 1'b0;
    cyc();
    total++;
    if (state !== 2'd2 || mag_on !== 1'b0) begin
      bad++; $display("FAIL door_pause got st=%0d mag=%b want st=2 mag=0", state, mag_on);
    end
    for (int i = 0; i < 5; i++) tick();
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h045 || state !== 2'd2) begin
      bad++; $display("FAIL pause_hold got=%h st=%0d want=045 st=2", {mins, sec_tens, sec_ones}, state);
    end
    door_closed = 1'b1;
    start();
    total++;
    if (state !== 2'd1 || mag_on !== 1'b1) begin
      bad++; $display("FAIL resume got st=%0d mag=%b want st=1 mag=1", state, mag_on);
    end
    tick();
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h044) begin
      bad++; $display("FAIL resume_tick got=%h want=044", {mins, sec_tens, sec_ones});
    end
    door_closed = 1'b0;
    tick();
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h044 || state !== 2'd2) begin
      bad++; $display("FAIL door_tick got=%h st=%0d want=044 st=2", {mins, sec_tens, sec_ones}, state);
    end
    door_closed = 1'b1;
  endtask

  task automatic test_done();
    clear();
    key(4'd1);
    start();
    tick();
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h000 || state !== 2'd3 || done !== 1'b1 || mag_on !== 1'b0) begin
      bad++; $display("FAIL final_tick got t=%h st=%0d done=%b mag=%b want t=000 st=3 done=1 mag=0",
                      {mins, sec_tens, sec_ones}, state, done, mag_on);
    end
    tick(); tick();
    total++;
    if (state !== 2'd3 || done !== 1'b1) begin
      bad++; $display("FAIL done_hold got st=%0d done=%b want st=3 done=1", state, done);
    end
    tick();
    total++;
    if (state !== 2'd0 || done !== 1'b0) begin
      bad++; $display("FAIL done_exit got st=%0d done=%b want st=0 done=0", state, done);
    end
    start();
    total++;
    if (state !== 2'd0 || mag_on !== 1'b0) begin
      bad++; $display("FAIL start_zero got st=%0d mag=%b want st=0 mag=0", state, mag_on);
    end
    key(4'd0); key(4'd5);
    start_btn = 1'b1;
    tick_1hz  = 1'b1;
    cyc();
    total++;
    if (state !== 2'd1 || {mins, sec_tens, sec_ones} !== 12'h005) begin
      bad++; $display("FAIL start_tick got st=%0d t=%h want st=1 t=005", state, {mins, sec_tens, sec_ones});
    end
    // Early cancel of DONE by stop.
    for (int i = 0; i < 5; i++) tick();
    stop();
    total++;
    if (state !== 2'd0 || done !== 1'b0) begin
      bad++; $display("FAIL done_cancel got st=%0d done=%b want st=0 done=0", state, done);
    end
  endtask

  task automatic test_999_reset();
    clear();
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h999) begin
      bad++; $display("FAIL keys_999 got=%h want=999", {mins, sec_tens, sec_ones});
    end
    start();
    tick();
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h998) begin
      bad++; $display("FAIL tick_998 got=%h want=998", {mins, sec_tens, sec_ones});
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++;
    if ({mins, sec_tens, sec_ones} !== 12'h000 || state !== 2'd0 || mag_on !== 1'b0) begin
      bad++; $display("FAIL reset_cook got t=%h st=%0d mag=%b want t=000 st=0 mag=0",
                      {mins, sec_tens, sec_ones}, state, mag_on);
    end
  endtask

  task automatic test_clear_stop();
    key(4'd2); key(4'd0);
    start();
    clear_btn = 1'b1;
    tick_1hz  = 1'b1;
    cyc();
    total++;
    if (state !== 2'd0 || {mins, sec_tens, sec_ones} !== 12'h000) begin
      bad++; $display("FAIL clear_tick got st=%0d t=%h want st=0 t=000", state, {mins, sec_tens, sec_ones});
    end
    key(4'd2); key(4'd0);
    start();
    stop();
    total++;
    if (state !== 2'd2 || {mins, sec_tens, sec_ones} !== 12'h020) begin
      bad++; $display("FAIL stop_pause got st=%0d t=%h want st=2 t=020", state, {mins, sec_tens, sec_ones});
    end
    stop();
    total++;
    if (state !== 2'd0 || {mins, sec_tens, sec_ones} !== 12'h000) begin
      bad++; $display("FAIL stop_cancel got st=%0d t=%h want st=0 t=000", state, {mins, sec_tens, sec_ones});
    end
  endtask

  initial begin
    reset       = 1'b1;
    tick_1hz    = 1'b0;
    key_valid   = 1'b0;
    key_digit   = 4'd0;
    start_btn   = 1'b0;
    stop_btn    = 1'b0;
    clear_btn   = 1'b0;
    door_closed = 1'b1;
    test_reset();
    test_keys_start();
    test_rollover();
    test_door_pause();
    test_done();
    test_999_reset();
    test_clear_stop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
